// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl
// Drives TEST/HOLD/SCANIN of a serial scan chain.
// - Shifts a parallel stimulus pattern into the chain, MSB first.
// - At the same time, captures the bits coming back on SCANOUT.
// - Can optionally insert functional capture clocks, then unload the
//   captured response with zero fill.
// - The unloaded word is presented on SOUT_DATA, qualified by a one-cycle DONE.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN  = 32,
    parameter int CNT_W      = 6,
    parameter int CAP_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 CAPTURE_EN,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] SIN_DATA,
    input  logic                 SCANOUT,
    output logic                 TEST,
    output logic                 HOLD,
    output logic                 SCANIN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] SOUT_DATA
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_FIN
    } state_t;

    // Counter values seen on the final edge of a shift/unload pass and of
    // the capture window.
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CAP   = CNT_W'(CAP_CYCLES - 1);

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [CHAIN_LEN-1:0]   sreg_reg, sreg_next;
    logic                   cap_reg, cap_next;
    logic [CHAIN_LEN-1:0]   sout_reg, sout_next;
    logic [CHAIN_LEN-1:0]   shifted;
    logic                   test_reg, test_next;
    logic                   hold_reg, hold_next;
    logic                   scanin_reg, scanin_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;

    // sreg shifted left by one, with the chain's serial output entering at
    // the LSB.
    // The pattern leaves from the MSB while the old chain contents fill in
    // behind it.
    assign shifted[0] = SCANOUT;
    generate
        for (genvar gi = 1; gi < CHAIN_LEN; gi++) begin : g_shift
            assign shifted[gi] = sreg_reg[gi-1];
        end
    endgenerate

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sreg_next  = sreg_reg;
        cap_next   = cap_reg;
        sout_next  = sout_reg;

        case (state_reg)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    sreg_next  = SIN_DATA;
                    cap_next   = CAPTURE_EN;
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sreg_next = shifted;
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == LAST_SHIFT) begin
                    cnt_next = '0;
                    if (cap_reg) begin
                        state_next = ST_CAPTURE;
                    end else begin
                        sout_next  = shifted;
                        state_next = ST_FIN;
                    end
                end
            end
            ST_CAPTURE: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_CAP) begin
                    cnt_next   = '0;
                    state_next = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                sreg_next = shifted;
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == LAST_SHIFT) begin
                    cnt_next   = '0;
                    sout_next  = shifted;
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Abort drops straight back to idle.
        // The previously reported result is kept, and no DONE pulse is issued.
        if (ABORT && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            sout_next  = sout_reg;
        end

        // The outputs are decoded from the state being entered, so they are
        // stable for the whole following cycle.
        test_next   = 1'b0;
        hold_next   = 1'b1;
        scanin_next = 1'b0;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        case (state_next)
            ST_SHIFT: begin
                test_next   = 1'b1;
                busy_next   = 1'b1;
                scanin_next = sreg_next[CHAIN_LEN-1];
            end
            ST_CAPTURE: begin
                hold_next = 1'b0;
                busy_next = 1'b1;
            end
            ST_UNLOAD: begin
                test_next = 1'b1;
                busy_next = 1'b1;
            end
            ST_FIN: begin
                done_next = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            sreg_reg   <= '0;
            cap_reg    <= 1'b0;
            sout_reg   <= '0;
            test_reg   <= 1'b0;
            hold_reg   <= 1'b1;
            scanin_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            sreg_reg   <= sreg_next;
            cap_reg    <= cap_next;
            sout_reg   <= sout_next;
            test_reg   <= test_next;
            hold_reg   <= hold_next;
            scanin_reg <= scanin_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign TEST      = test_reg;
    assign HOLD      = hold_reg;
    assign SCANIN    = scanin_reg;
    assign BUSY      = busy_reg;
    assign DONE      = done_reg;
    assign SOUT_DATA = sout_reg;

endmodule
